// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: FIR sample stream in, 16-sample parallel frames out.
// Optional FRAME_BUF_DROP_CNT_EN adds a saturating count of discarded samples.
module fir_frame_buffer #(
    parameter int FRAME_LEN = 16,
    parameter int DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fir_valid,
    input  logic [DATA_W-1:0]             fir_d,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [FRAME_LEN*DATA_W-1:0]   frame_data,
    output logic [7:0]                    frame_cnt,
    output logic                          overflow
`ifdef FRAME_BUF_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_st_e;

    bank_st_e          st_q [2];
    bank_st_e          st_d [2];
    logic [DATA_W-1:0] mem_q [2][FRAME_LEN];
    logic [DATA_W-1:0] mem_d [2][FRAME_LEN];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic              xfer, wr_ok, drop;

    assign xfer  = (st_q[rd_bank_q] == FULL) && frame_ready;
    assign wr_ok = fir_valid && (st_q[wr_bank_q] != FULL);
    assign drop  = fir_valid && (st_q[wr_bank_q] == FULL);

    // Write and read never touch the same bank on one edge: the read bank
    // is FULL and the write bank is not.
    always_comb begin
        st_d        = st_q;
        mem_d       = mem_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        if (xfer) begin
            st_d[rd_bank_q] = EMPTY;
            rd_bank_d       = ~rd_bank_q;
            frame_cnt_d     = frame_cnt_q + 8'd1;
        end
        if (wr_ok) begin
            mem_d[wr_bank_q][wr_idx_q] = fir_d;
            st_d[wr_bank_q]            = FILLING;
            if (wr_idx_q == IDX_W'(FRAME_LEN - 1)) begin
                st_d[wr_bank_q] = FULL;
                wr_bank_d       = ~wr_bank_q;
                wr_idx_d        = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= '{default: EMPTY};
            mem_q       <= '{default: '{default: '0}};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            mem_q       <= mem_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef FRAME_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Frame bus comes straight from the read bank's storage.
    always_comb begin
        frame_data = '0;
        for (int n = 0; n < FRAME_LEN; n++) begin
            frame_data[n*DATA_W +: DATA_W] = mem_q[rd_bank_q][n];
        end
    end

    assign frame_valid = (st_q[rd_bank_q] == FULL);
    assign frame_cnt   = frame_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Scoreboard bench for fir_frame_buffer against a queue-based frame model.
// Build with FRAME_BUF_DROP_CNT_EN to also cover drop_cnt.
module tb_fir_frame_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         fir_valid;
    logic [15:0]  fir_d;
    logic         frame_valid;
    logic         frame_ready;
    logic [255:0] frame_data;
    logic [7:0]   frame_cnt;
    logic         overflow;
`ifdef FRAME_BUF_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    fir_frame_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .fir_valid   (fir_valid),
        .fir_d       (fir_d),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow)
`ifdef FRAME_BUF_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a partial frame being assembled plus a FIFO of
    // completed frames (at most two may be waiting).
    logic [255:0] part;
    int           part_n;
    logic [255:0] full_q[$];
    logic [255:0] sb_q[$];
    logic [7:0]   m_cnt;
    logic         m_ovf;
    logic [7:0]   m_drop;
    bit           mon_en   = 0;
    bit           zero_chk = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v,
                              input logic [15:0] d, input logic rdy);
        int  pre;
        bit  x;
        if (r) begin
            part     = '0;
            part_n   = 0;
            full_q   = {};
            sb_q     = {};
            m_cnt    = '0;
            m_ovf    = 1'b0;
            m_drop   = '0;
            mon_en   = 1;
            zero_chk = 1;
            return;
        end
        pre = full_q.size();
        x   = (pre > 0) && rdy;
        if (v) begin
            if (pre == 2) begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop++;
            end else begin
                part[part_n*16 +: 16] = d;
                part_n++;
                if (part_n == 16) begin
                    full_q.push_back(part);
                    sb_q.push_back(part);
                    part   = '0;
                    part_n = 0;
                end
            end
        end
        if (x) begin
            void'(full_q.pop_front());
            m_cnt++;
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [15:0] d, input logic rdy);
        rst         = r;
        fir_valid   = v;
        fir_d       = d;
        frame_ready = rdy;
        @(posedge clk);
        model_edge(r, v, d, rdy);
        #1;
    endtask

    // Monitor: checks flags every cycle, compares presented frames with the
    // scoreboard head and retires them on the handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("frame_valid", 256'(frame_valid), 256'(full_q.size() > 0));
            chk("overflow", 256'(overflow), 256'(m_ovf));
            chk("frame_cnt", 256'(frame_cnt), 256'(m_cnt));
`ifdef FRAME_BUF_DROP_CNT_EN
            chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
`endif
            if (zero_chk) begin
                chk("reset_data", frame_data, '0);
                zero_chk = 0;
            end
            if (frame_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 256'(frame_valid), 256'(0));
                end else begin
                    chk("frame_data", frame_data, sb_q[0]);
                    if (frame_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        // reset, then frame 0..15 with ready high
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 16'(i), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // ready low: 16..47 fills both banks, 48 is dropped, then drain
        for (int i = 16; i < 49; i++) step(0, 1, 16'(i), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // gap mid-frame
        for (int i = 0; i < 10; i++) step(0, 1, 16'(16'h100 + i), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        for (int i = 10; i < 16; i++) step(0, 1, 16'(16'h100 + i), 1);
        step(0, 0, 0, 1);

        // reset after a partial frame, then after a full bank
        for (int i = 0; i < 8; i++) step(0, 1, 16'(16'h200 + i), 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 16'(16'h300 + i), 0);
        step(1, 1, 16'hDEAD, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 16'(16'h400 + i), 1);
        step(0, 0, 0, 1);

        // B completes on the same edge A is read
        for (int i = 0; i < 31; i++) step(0, 1, 16'(16'h500 + i), 0);
        step(0, 1, 16'h051F, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // long stall: drop counter saturation
        for (int i = 0; i < 300; i++) step(0, 1, 16'($urandom), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 9) < 7),
                 16'($urandom),
                 ($urandom_range(0, 3) < bias + 1));
        end
        step(0, 0, 0, 0);
        chk("sb_pending", 256'(sb_q.size()), 256'(full_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
